// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide.
// Holds the pipeline via a combinational stall until the registered result is ready.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            is_muldiv,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic                neg_res_q;
  logic                neg_rem_q;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     b_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN:0]       rem_q;

  logic                accept;
  logic                is_div;
  logic                sign_a_op;
  logic                sign_b_op;
  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     abs_a;
  logic [XLEN-1:0]     abs_b;
  logic                div_zero;
  logic                div_ovf;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN+1:0]     div_shift;
  logic [XLEN+1:0]     div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     fix_res;

  assign is_muldiv = (ALUOp == 3'b010) && (Funct7 == 7'b0000001);
  assign accept    = start && is_muldiv && (state_q == S_IDLE) && !flush;
  assign stall     = accept || (state_q == S_RUN) || (state_q == S_FIX);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

  // Operand signedness per Funct3, then magnitudes and special-case detection
  assign is_div    = Funct3[2];
  assign sign_a_op = is_div ? !Funct3[0] : ((Funct3[1:0] == 2'b01) || (Funct3[1:0] == 2'b10));
  assign sign_b_op = is_div ? !Funct3[0] : (Funct3[1:0] == 2'b01);
  assign neg_a     = sign_a_op && SrcA[XLEN-1];
  assign neg_b     = sign_b_op && SrcB[XLEN-1];
  assign abs_a     = neg_a ? -SrcA : SrcA;
  assign abs_b     = neg_b ? -SrcB : SrcB;
  assign div_zero  = is_div && (SrcB == '0);
  assign div_ovf   = is_div && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = Funct3[1] ? SrcA : '1;
    else if (div_ovf) special_res = Funct3[1] ? '0 : SrcA;
  end

  // One iteration step of each datapath
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {rem_q, a_q[XLEN-1]};
  assign div_diff  = div_shift - {2'b00, b_q};
  assign div_ge    = !div_diff[XLEN+1];

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -a_q : a_q;
  assign rem  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      result    <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q      <= Funct3;
            neg_res_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            a_q       <= abs_a;
            b_q       <= abs_b;
            acc_q     <= {{XLEN{1'b0}}, abs_b};
            rem_q     <= '0;
            cnt_q     <= CW'(XLEN);
            if (div_zero || div_ovf) begin
              result  <= special_res;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (op_q[2]) begin
            rem_q <= div_ge ? div_diff[XLEN:0] : div_shift[XLEN:0];
            a_q   <= {a_q[XLEN-2:0], div_ge};
          end else begin
            acc_q <= mul_next;
          end
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result  <= fix_res;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, stall profile,
// special cases, flush/reset aborts, non-M ops and start held through DONE.
module tb_muldiv_sequencer;
  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      ALUOp = 3'b000;
  logic [6:0]      Funct7 = 7'b0000000;
  logic [2:0]      Funct3 = 3'b000;
  logic [XLEN-1:0] SrcA = '0;
  logic [XLEN-1:0] SrcB = '0;
  logic            is_muldiv;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .is_muldiv(is_muldiv), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    ALUOp  = 3'b010;
    Funct7 = 7'b0000001;
    Funct3 = f3;
    SrcA   = a;
    SrcB   = b;
    start  = 1'b1;
  endtask

  // Launch one op in cycle 0 and follow it until done, checking latency, result and stall
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat,
                        input bit hold_start);
    int cyc;
    int done_cyc;
    int stall_bad;
    set_op(f3, a, b);
    #1;
    check({tag, " stall0"}, 32'(stall), 32'd1);
    cyc = 0;
    done_cyc = -1;
    stall_bad = 0;
    while (done_cyc < 0 && cyc < 100) begin
      tick();
      cyc++;
      if (!hold_start) start = 1'b0;
      #1;
      if (stall !== (cyc < lat)) stall_bad++;
      if (done === 1'b1) done_cyc = cyc;
    end
    check({tag, " latency"}, 32'(done_cyc), 32'(lat));
    check({tag, " result"}, result, exp);
    check({tag, " stall profile"}, 32'(stall_bad), 32'd0);
    tick();
    start = 1'b0;
    #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " idle after"}, 32'(busy), 32'd0);
    check({tag, " stall after"}, 32'(stall), 32'd0);
  endtask

  initial begin
    int seen;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset result", result, 32'h0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    tick();

    run_op("MUL 7*-3",        3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
    run_op("MULH min*min",    3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 34, 1'b0);
    run_op("MULH -1*5",       3'b001, 32'hFFFFFFFF,  32'd5,        32'hFFFFFFFF, 34, 1'b0);
    run_op("MULHSU",          3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 34, 1'b0);
    run_op("MULHU",           3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
    run_op("DIV -7/2",        3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 34, 1'b0);
    run_op("REM -7/2",        3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 34, 1'b0);
    run_op("DIVU",            3'b101, 32'hFFFFFFFE,  32'hF,        32'h11111110, 34, 1'b0);
    run_op("REMU",            3'b111, 32'hFFFFFFFE,  32'hF,        32'h0000000E, 34, 1'b0);
    run_op("DIV 5/0",         3'b100, 32'd5,         32'd0,        32'hFFFFFFFF, 1,  1'b0);
    run_op("REM 5/0",         3'b110, 32'd5,         32'd0,        32'd5,        1,  1'b0);
    run_op("REMU 5/0",        3'b111, 32'd5,         32'd0,        32'd5,        1,  1'b0);
    run_op("DIV ovf",         3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
    run_op("REM ovf",         3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h0,        1,  1'b0);
    run_op("DIVU 100/7",      3'b101, 32'd100,       32'd7,        32'd14,       34, 1'b0);

    // Flush in cycle 10 of a DIVU
    set_op(3'b101, 32'hFFFFFFFE, 32'hF);
    #1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush idle", 32'(busy), 32'd0);
    check("flush stall", 32'(stall), 32'd0);
    check("flush result", result, 32'd14);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("flush no done", 32'(seen), 32'd0);
    check("flush result held", result, 32'd14);

    // Reset in cycle 10 of a DIVU
    set_op(3'b101, 32'hFFFFFFFE, 32'hF);
    #1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort reset idle", 32'(busy), 32'd0);
    check("abort reset result", result, 32'h0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort reset quiet", 32'(seen), 32'd0);

    // Non-M instruction (ADD) with start held
    ALUOp  = 3'b010;
    Funct7 = 7'b0000000;
    Funct3 = 3'b000;
    SrcA   = 32'd3;
    SrcB   = 32'd4;
    start  = 1'b1;
    #1;
    check("ADD is_muldiv", 32'(is_muldiv), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (stall === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    check("ADD no stall", 32'(seen), 32'd0);
    check("ADD result", result, 32'h0);
    start = 1'b0;

    // start held high through DONE must not relaunch
    run_op("MUL hold start",  3'b000, 32'd3,         32'd4,        32'd12,       34, 1'b1);
    tick();
    check("hold start still idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle RISC-V M-extension unit that sits beside the single-cycle ALU in the EX stage. It decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU from the same ALUOp/Funct7/Funct3 fields the ALU controller consumes. It runs an iterative radix-2 multiply or restoring divide, generalised to any XLEN. It holds the pipeline with a stall output until the result is ready.

## Interface
- XLEN, 32, datapath width; even, ≥ 4
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  EX-stage instruction valid this cycle
- flush  input  1  synchronous kill of any in-flight operation
- ALUOp  input  3  controller ALU opcode
- Funct7  input  7  instruction bits 31:25
- Funct3  input  3  instruction bits 14:12
- SrcA  input  XLEN  rs1 operand (dividend / multiplicand)
- SrcB  input  XLEN  rs2 operand (divisor / multiplier)
- is_muldiv  output  1  combinational decode: ALUOp==3'b010 && Funct7==7'b0000001
- stall  output  1  freeze IF/ID/EX; combinational
- busy  output  1  state is not IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  registered result, held until the next completion

## Operation
- Funct3 map: 000 MUL (low XLEN of product), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept: the operation is accepted when start && is_muldiv && state==IDLE && !flush. start is ignored in every other state.
- Capture on accept:
  - Absolute values of the signed operands.
  - Sign-fix flags: product sign = signA^signB. Quotient sign = signA^signB. Remainder sign = signA.
  - Op type.
  - Iteration counter set to XLEN.
- States:
  - IDLE → RUN on a normal accept.
  - IDLE → DONE on a special-case accept.
  - RUN → FIX when the counter reaches 0.
  - FIX → DONE.
  - DONE → IDLE unconditionally.
- RUN (XLEN cycles, one bit per cycle):
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring subtract on a remainder of XLEN+1 bits; quotient shifted in LSB-first.
- FIX: two's-complement negation where the sign flag is set. Selects the low half, high half, quotient or remainder into result.
- Special cases are decided at accept and bypass RUN/FIX:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → SrcA.
  - Signed overflow (SrcA = 1 followed by XLEN-1 zeros, SrcB = all ones): DIV → SrcA; REM → 0.
- done is high only in DONE. result is written on the FIX→DONE or IDLE→DONE transition.
- flush in any state: next state is IDLE. done does not fire and result is unchanged. flush has priority over accept.
- reset: state IDLE, result 0, done 0, busy 0, counter 0. Reset has priority over flush.
- A non-M instruction (is_muldiv=0) never affects state, stall or result.

## Timing
- Cycle 0 is the accept cycle.
  - stall = (start && is_muldiv && state==IDLE && !flush) || state==RUN || state==FIX.
  - stall is therefore high in cycle 0 combinationally, before any register changes.
- Normal path:
  - RUN occupies cycles 1..XLEN.
  - FIX occupies cycle XLEN+1.
  - DONE occupies cycle XLEN+2, with done=1 and stall=0.
  - Total latency is XLEN+2; stall is high in cycles 0..XLEN+1.
- Special path: DONE in cycle 1, with stall high only in cycle 0.
- In the DONE cycle the pipeline advances. start may still be high for the completing instruction and is ignored. The next instruction is sampled in IDLE the following cycle.
- Back-to-back M ops therefore cost XLEN+3 cycles each.
- busy is high in RUN, FIX and DONE, and low in IDLE.

## Test plan
- MUL, SrcA=7, SrcB=0xFFFFFFFD (XLEN=32):
  - result=0xFFFFFFEB, done in cycle 34.
  - stall high in cycles 0–33 only.
- Multiply-high ops:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV −7/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFE/0xF → 0x11111110.
  - REMU 0xFFFFFFFE/0xF → 0xE.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with done in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each with done in cycle 1.
- Abort paths:
  - Start DIVU, then assert flush in cycle 10: state is IDLE in cycle 11, no done pulse, result keeps its prior value.
  - Repeat with reset instead of flush: result=0.
- Non-M op and DONE-cycle start:
  - ADD (ALUOp=010, Funct7=0) with start=1: is_muldiv=0, stall never asserted.
  - start held high through DONE: no second operation is launched.
